// File: rtl/cpu_bcd_store.sv
// CHIP-8 FX33 sequencer: latches VX and I, converts VX to BCD and writes the
// hundreds, tens and ones digits to I, I+1 and I+2 over a wr_en/ack handshake.

module cpu_bcd (
  input  logic [7:0] bin,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [19:0] sr;

  // Double-dabble: add 3 to any digit >= 5 before each shift.
  always_comb begin
    sr = {12'd0, bin};
    for (int i = 0; i < 8; i++) begin
      if (sr[11:8] >= 4'd5)  sr[11:8]  = sr[11:8]  + 4'd3;
      if (sr[15:12] >= 4'd5) sr[15:12] = sr[15:12] + 4'd3;
      if (sr[19:16] >= 4'd5) sr[19:16] = sr[19:16] + 4'd3;
      sr = sr << 1;
    end
  end

  assign hundreds = sr[19:16];
  assign tens     = sr[15:12];
  assign ones     = sr[11:8];
endmodule

module cpu_bcd_store #(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            value,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wr_data,
  input  logic                  mem_wr_ack
);
  typedef enum logic [2:0] {StIdle, StWrHundreds, StWrTens, StWrOnes, StDone} state_e;

  state_e                state_q;
  logic [7:0]            val_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            hundreds, tens, ones;

  cpu_bcd u_bcd (
    .bin      (val_q),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      val_q     <= 8'd0;
      addr_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_wr_en <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            val_q     <= value;
            addr_q    <= base_addr;
            busy      <= 1'b1;
            mem_wr_en <= 1'b1;
            state_q   <= StWrHundreds;
          end
        end
        StWrHundreds: if (mem_wr_ack) state_q <= StWrTens;
        StWrTens:     if (mem_wr_ack) state_q <= StWrOnes;
        StWrOnes: begin
          if (mem_wr_ack) begin
            mem_wr_en <= 1'b0;
            done      <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          mem_wr_en <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Address and data are decoded from registered state only; zero when not writing.
  always_comb begin
    mem_addr    = '0;
    mem_wr_data = 8'd0;
    case (state_q)
      StWrHundreds: begin
        mem_addr    = addr_q;
        mem_wr_data = {4'd0, hundreds};
      end
      StWrTens: begin
        mem_addr    = addr_q + ADDR_WIDTH'(1);
        mem_wr_data = {4'd0, tens};
      end
      StWrOnes: begin
        mem_addr    = addr_q + ADDR_WIDTH'(2);
        mem_wr_data = {4'd0, ones};
      end
      default: ;
    endcase
  end
endmodule
